muldiv_ctrl: RTL

Iterative multiply/divide sequencer beside the EX stage ALU. It takes MULT/MULTU/DIV/DIVU requests from ID/EX operands after forwarding, runs a 32-iteration shift-add or restoring-divide sequence, and holds the pipeline with `stall` while busy. Results land in architectural HI/LO registers, which are also writable directly (MTHI/MTLO).

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// The divider is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_FIX  = ST_FIX,
        S_DONE = ST_DONE
    } state_e;

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage request/result bundle for muldiv_ctrl; the pipeline side is master.
interface muldiv_ctrl_if import muldiv_pkg::*; #(parameter int WIDTH = ITER);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wdata,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
        output stall, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring subtract for divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv_i,
    input  logic [WIDTH-1:0] accHi_i,
    input  logic [WIDTH-1:0] accLo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] accHi_o,
    output logic [WIDTH-1:0] accLo_o
);

    logic [WIDTH:0] mulSum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] divShift;
    logic           divFits;
`else
    logic           unusedIsDiv;
    assign unusedIsDiv = isDiv_i;
`endif

    always_comb begin
        mulSum  = {1'b0, accHi_i} + (accLo_i[0] ? {1'b0, opnd_i} : '0);
        accHi_o = mulSum[WIDTH:1];
        accLo_o = {mulSum[0], accLo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Partial remainder is always below the divisor, so a W-bit subtract is exact.
        divShift = {accHi_i, accLo_i[WIDTH-1]};
        divFits  = divShift[WIDTH] || (divShift[WIDTH-1:0] >= opnd_i);
        if (isDiv_i) begin
            accHi_o = divFits ? (divShift[WIDTH-1:0] - opnd_i) : divShift[WIDTH-1:0];
            accLo_o = {accLo_i[WIDTH-2:0], divFits};
        end
`endif
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, sign latches and HI/LO.
// Define MULDIV_DIV_EN to add DIV/DIVU; otherwise divide requests are ignored.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int WIDTH = ITER
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   accHi_q;
    logic [WIDTH-1:0]   accLo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               signA_q;
    logic               signB_q;
    logic               isDiv_q;
    logic               done_q;

    logic [WIDTH-1:0]   stepHi_d;
    logic [WIDTH-1:0]   stepLo_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [2*WIDTH-1:0] prod;
    logic               idleLike;
    logic               opLegal;
    logic               reqDiv;
    logic               reqSigned;
    logic               startAcc;

    always_comb begin
        idleLike = (state_q == S_IDLE) || (state_q == S_DONE);
`ifdef MULDIV_DIV_EN
        opLegal = 1'b1;
        reqDiv  = bus.op[1];
`else
        opLegal = ~bus.op[1];
        reqDiv  = 1'b0;
`endif
        startAcc  = idleLike && bus.start && !bus.flush && opLegal;
        reqSigned = isSignedOp(bus.op);
        absA = (reqSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        absB = (reqSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Sign fixup applied in FIX; signs are only latched for signed ops.
    always_comb begin
        prod = {accHi_q, accLo_q};
        if (signA_q ^ signB_q) begin
            prod = -prod;
        end
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (isDiv_q) begin
            lo_d = (signA_q ^ signB_q) ? -accLo_q : accLo_q;
            hi_d = signA_q ? -accHi_q : accHi_q;
        end
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv_i (isDiv_q),
        .accHi_i (accHi_q),
        .accLo_i (accLo_q),
        .opnd_i  (opnd_q),
        .accHi_o (stepHi_d),
        .accLo_o (stepLo_d)
    );

    assign bus.stall = (state_q == S_CALC) || (state_q == S_FIX) || startAcc;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            accHi_q <= '0;
            accLo_q <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            isDiv_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (idleLike && !startAcc) begin
                if (bus.wr_hi) hi_q <= bus.wdata;
                if (bus.wr_lo) lo_q <= bus.wdata;
            end
            if (bus.flush && state_q != S_IDLE) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        state_q <= S_IDLE;
                        if (startAcc) begin
                            state_q <= S_CALC;
                            cnt_q   <= '0;
                            accHi_q <= '0;
                            // Divide shifts the dividend through accLo; multiply shifts the multiplier.
                            accLo_q <= reqDiv ? absA : absB;
                            opnd_q  <= reqDiv ? absB : absA;
                            signA_q <= reqSigned & bus.a[WIDTH-1];
                            signB_q <= reqSigned & bus.b[WIDTH-1];
                            isDiv_q <= reqDiv;
                        end
                    end
                    S_CALC: begin
                        accHi_q <= stepHi_d;
                        accLo_q <= stepLo_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
